// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer
//   Valid/ready FIFO that holds up to DEPTH entries in a circular store.
//   An item takes one cycle to appear: data written on one edge is visible
//   on outs after that edge, and never on the same edge it is accepted.
//   ins_ready and outs_valid come only from registered occupancy, so there
//   is no combinational path from either side of the handshake to the other.
//
// Parameters
//   DATA_WIDTH  payload width in bits
//   DEPTH       number of storage slots (power of two, >= 2)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset; clears the store and occupancy
//   ins         upstream payload
//   ins_valid   upstream payload valid
//   ins_ready   buffer can accept (count < DEPTH)
//   outs        head-of-queue payload (store[rd_ptr])
//   outs_valid  head entry present (count != 0)
//   outs_ready  downstream accepts
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  enq;
    logic                  deq;

    // A full buffer stays not-ready even when the head is being taken this
    // cycle; space only opens after the dequeuing edge.
    assign ins_ready  = (count < DEPTH_CNT);
    assign outs_valid = (count != '0);
    assign outs       = store[rd_ptr];

    assign enq = ins_valid & ins_ready;
    assign deq = outs_valid & outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (enq) begin
            store[wr_ptr] <= ins;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
